alu_bist_ctrl: RTL and testbench
================================

Name: alu_bist_ctrl

Overview:
- Built-in self-test controller for the 32-bit ALU: drives the ALU operand/select inputs with a deterministic sweep and consumes its results.
- Sweep: every select code, with a stepped grid of operand values.
- Compacts y_out, flag and sum_out into a 32-bit MISR signature, then compares it against a golden signature.
- Sits beside alu_32bit: it owns the ALU input side during test and observes the ALU output side.

Parameters:
- WIDTH, 32, operand/result width.
- SEL_W, 4, select width; the sweep covers 2**SEL_W codes.
- N_STEPS, 10, operand grid points per operand (i and j range over 0..N_STEPS-1).
- A_STEP, 1000, a operand increment per i step.
- B_STEP, 2000, b operand increment per j step.
- ALU_LAT, 1, ALU result latency in cycles; must be 1..4.
- MISR_SEED, 32'hFFFF_FFFF, signature value loaded on start.
- MISR_POLY, 32'h04C1_1DB7, MISR feedback polynomial.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a run.
- golden_sig  in  32  expected final signature; sampled when the run completes.
- alu_a  out  WIDTH  operand A to the ALU.
- alu_b  out  WIDTH  operand B to the ALU.
- alu_sel  out  SEL_W  operation select to the ALU.
- alu_vld  out  1  high while alu_a/alu_b/alu_sel carry a valid vector.
- alu_y  in  WIDTH  ALU result.
- alu_flag  in  1  ALU flag.
- alu_sum  in  WIDTH+1  ALU carry-extended sum.
- busy  out  1  high while a run is in progress.
- done  out  1  high in DONE state.
- pass  out  1  valid while done is high: signature == golden_sig.
- signature  out  32  current MISR value.
- vec_count  out  16  number of vectors captured so far in this run.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (rst).
- Reset values: all outputs 0, except signature = MISR_SEED. State = IDLE. Loop counters = 0.
- States: IDLE, ISSUE, DRAIN, DONE. Reset from any state, including mid-run, returns to IDLE on the next edge.
- IDLE -> ISSUE on start=1. On that edge:
  - counters k=i=j=0; signature=MISR_SEED; vec_count=0;
  - busy=1, done=0, pass=0;
  - first vector registered onto outputs.
- ISSUE: one vector per cycle, alu_vld=1.
  - alu_a = i*A_STEP, alu_b = j*B_STEP, alu_sel = k.
  - Products come from accumulators (add step on increment, clear on wrap); no multipliers.
  - j is innermost, then i, then k outermost.
  - Total vectors V = 2**SEL_W * N_STEPS * N_STEPS (1600 at defaults).
  - After the vector k=2**SEL_W-1, i=j=N_STEPS-1 is issued: go to DRAIN, alu_vld=0, alu_a/alu_b/alu_sel hold their last values.
- Capture: alu_vld is delayed by ALU_LAT through a shift register. When the delayed valid is 1, ALU outputs are sampled that cycle.
  - d = alu_y ^ alu_sum[31:0] ^ {30'b0, alu_sum[32], alu_flag}.
  - signature <= ({signature[30:0],1'b0} ^ (signature[31] ? MISR_POLY : 0)) ^ d.
  - vec_count <= vec_count+1.
- DRAIN: stays until the delay pipe is empty and vec_count == V, then -> DONE.
  - On that edge: busy=0, done=1, pass=(signature==golden_sig), using the final signature value.
- DONE: done, pass and signature hold. start=1 starts a new run exactly as from IDLE (done drops on that edge).
- Timing: start high at edge T gives:
  - vectors on edges T..T+V-1;
  - last capture at edge T+V-1+ALU_LAT;
  - done=1 visible after edge T+V+ALU_LAT.
- start while busy is ignored. golden_sig is only sampled on DRAIN->DONE.
- vec_count does not wrap at defaults; V must be < 65536.

Test Plan:
- Reset, then start with an ALU model of latency 1 -> first three vectors (a,b,sel) = (0,0,0), (0,2000,0), (0,4000,0). Vector 11 = (1000,2000,0). Vector 100 = (0,0,1). Last vector = (9000,18000,15). alu_vld high for exactly 1600 cycles.
- ALU model returning all zeros, golden_sig = reference-model signature (seed clocked 1600 times) -> done=1 at T+1601, pass=1, vec_count=1600.
- Same run with golden_sig XOR 1 -> pass=0, done=1, signature unchanged from the previous case.
- Single corrupted result (alu_flag=1 on vector 777 only) -> signature differs from the fault-free value, pass=0.
- rst=1 asserted at vector 500, then start again -> all outputs are reset values one edge after rst. The second run gives the same signature as a clean run.
- start pulsed during ISSUE and again in DONE -> the first pulse has no effect; the second restarts the run with signature=MISR_SEED and done cleared on the next edge.
- ALU_LAT=3 build -> done=1 at T+1603 with a signature identical to the latency-1 run for the same ALU function.

Source files
------------

// File: rtl/alu_bist_ctrl.sv
// BIST controller for the 32-bit ALU: sweeps select codes over an operand
// grid, compacts ALU results into a MISR and compares against a golden value.
module alu_bist_ctrl #(
  parameter int          WIDTH     = 32,
  parameter int          SEL_W     = 4,
  parameter int          N_STEPS   = 10,
  parameter int          A_STEP    = 1000,
  parameter int          B_STEP    = 2000,
  parameter int          ALU_LAT   = 1,
  parameter logic [31:0] MISR_SEED = 32'hFFFF_FFFF,
  parameter logic [31:0] MISR_POLY = 32'h04C1_1DB7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      golden_sig,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  output logic             alu_vld,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_flag,
  input  logic [WIDTH:0]   alu_sum,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [31:0]      signature,
  output logic [15:0]      vec_count
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  localparam int CW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int V  = (2**SEL_W) * N_STEPS * N_STEPS;

  localparam logic [CW-1:0]    NMAX = CW'(N_STEPS - 1);
  localparam logic [SEL_W-1:0] KMAX = '1;
  localparam logic [15:0]      VCNT = 16'(V);
  localparam logic [WIDTH-1:0] AINC = WIDTH'(A_STEP);
  localparam logic [WIDTH-1:0] BINC = WIDTH'(B_STEP);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   k_q, k_d;
  logic [CW-1:0]      i_q, i_d;
  logic [CW-1:0]      j_q, j_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [ALU_LAT-1:0] pipe_q, pipe_d;
  logic [31:0]        sig_q, sig_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic        vld_nxt;
  logic        capture;
  logic        last;
  logic [31:0] din;
  logic [31:0] sig_sh;

  // pipe_q[0] is the issued valid; the top bit marks results to capture
  assign capture = pipe_q[ALU_LAT-1];
  assign last    = (k_q == KMAX) && (i_q == NMAX) && (j_q == NMAX);

  assign din = alu_y[31:0] ^ alu_sum[31:0]
             ^ {30'b0, alu_sum[WIDTH], alu_flag};

  assign sig_sh = {sig_q[30:0], 1'b0}
                ^ (sig_q[31] ? MISR_POLY : 32'h0);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    i_d     = i_q;
    j_d     = j_q;
    a_d     = a_q;
    b_d     = b_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    vld_nxt = 1'b0;

    if (capture) begin
      sig_d = sig_sh ^ din;
      cnt_d = cnt_q + 16'd1;
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = ISSUE;
          k_d     = '0;
          i_d     = '0;
          j_d     = '0;
          a_d     = '0;
          b_d     = '0;
          sig_d   = MISR_SEED;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          vld_nxt = 1'b1;
        end
      end
      ISSUE: begin
        if (last) begin
          state_d = DRAIN;
        end else begin
          vld_nxt = 1'b1;
          if (j_q == NMAX) begin
            j_d = '0;
            b_d = '0;
            if (i_q == NMAX) begin
              i_d = '0;
              a_d = '0;
              k_d = k_q + 1'b1;
            end else begin
              i_d = i_q + 1'b1;
              a_d = a_q + AINC;
            end
          end else begin
            j_d = j_q + 1'b1;
            b_d = b_q + BINC;
          end
        end
      end
      DRAIN: begin
        if ((pipe_q == '0) && (cnt_q == VCNT)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (sig_q == golden_sig);
        end
      end
      default: state_d = IDLE;
    endcase

    pipe_d    = pipe_q << 1;
    pipe_d[0] = vld_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      pipe_q  <= '0;
      sig_q   <= MISR_SEED;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      i_q     <= i_d;
      j_q     <= j_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pipe_q  <= pipe_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = k_q;
  assign alu_vld   = pipe_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign vec_count = cnt_q;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Directed bench for alu_bist_ctrl: latency-1 and latency-3 builds
// run side by side against a simple ALU stand-in.
module tb_alu_bist_ctrl;

  localparam logic [31:0] SEED = 32'hFFFF_FFFF;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] golden = '0;
  bit          zero_mode = 1'b0;
  bit          fault = 1'b0;

  logic [31:0] a1, b1, y1, sig1;
  logic [3:0]  sel1;
  logic        vld1, f1, busy1, done1, pass1;
  logic [32:0] s1;
  logic [15:0] cnt1;

  logic [31:0] a3, b3, y3, sig3, y3c, y3r;
  logic [3:0]  sel3;
  logic        vld3, f3, busy3, done3, pass3, f3c, f3r;
  logic [32:0] s3, s3c, s3r;
  logic [15:0] cnt3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] fy(input logic [31:0] a, b,
                                     input logic [3:0] s, input bit z);
    return z ? 32'h0 : (a ^ b) + {28'b0, s};
  endfunction

  function automatic logic [32:0] fs(input logic [31:0] a, b, input bit z);
    return z ? 33'h0 : {1'b0, a} + {1'b0, ~b};
  endfunction

  function automatic logic ff(input logic [31:0] a, b, input logic [3:0] s,
                              input logic v, input bit z, input bit flt);
    return (!z & s[0]) |
           (flt && v && a == 32'd7000 && b == 32'd14000 && s == 4'd7);
  endfunction

  function automatic logic [31:0] misr(input logic [31:0] sg, y,
                                       input logic f, input logic [32:0] s);
    logic [31:0] d;
    d = y ^ s[31:0] ^ {30'b0, s[32], f};
    return ({sg[30:0], 1'b0} ^ (sg[31] ? POLY : 32'h0)) ^ d;
  endfunction

  function automatic logic [31:0] ref_sig(input bit z, input bit flt);
    logic [31:0] sg, a, b;
    logic [3:0]  s;
    sg = SEED;
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < 10; i++)
        for (int j = 0; j < 10; j++) begin
          a  = 32'(i * 1000);
          b  = 32'(j * 2000);
          s  = 4'(k);
          sg = misr(sg, fy(a, b, s, z), ff(a, b, s, 1'b1, z, flt),
                    fs(a, b, z));
        end
    return sg;
  endfunction

  assign y1 = fy(a1, b1, sel1, zero_mode);
  assign s1 = fs(a1, b1, zero_mode);
  assign f1 = ff(a1, b1, sel1, vld1, zero_mode, fault);

  assign y3c = fy(a3, b3, sel3, zero_mode);
  assign s3c = fs(a3, b3, zero_mode);
  assign f3c = ff(a3, b3, sel3, vld3, zero_mode, fault);

  always_ff @(posedge clk) begin
    y3r <= y3c;
    s3r <= s3c;
    f3r <= f3c;
    y3  <= y3r;
    s3  <= s3r;
    f3  <= f3r;
  end

  alu_bist_ctrl #(.ALU_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .golden_sig(golden),
    .alu_a(a1), .alu_b(b1), .alu_sel(sel1), .alu_vld(vld1),
    .alu_y(y1), .alu_flag(f1), .alu_sum(s1),
    .busy(busy1), .done(done1), .pass(pass1),
    .signature(sig1), .vec_count(cnt1)
  );

  alu_bist_ctrl #(.ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .golden_sig(golden),
    .alu_a(a3), .alu_b(b3), .alu_sel(sel3), .alu_vld(vld3),
    .alu_y(y3), .alu_flag(f3), .alu_sum(s3),
    .busy(busy3), .done(done3), .pass(pass3),
    .signature(sig3), .vec_count(cnt3)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit vec_chk);
    int n = 0, v = 0, d1 = -1, d3 = -1;
    int idx[6]        = '{0, 1, 2, 11, 100, 1599};
    logic [31:0] ea[6] = '{0, 0, 0, 1000, 0, 9000};
    logic [31:0] eb[6] = '{0, 2000, 4000, 2000, 0, 18000};
    logic [3:0]  es[6] = '{0, 0, 0, 0, 1, 15};
    while ((d1 < 0 || d3 < 0) && n < 2100) begin
      if (vec_chk)
        foreach (idx[x])
          if (n == idx[x]) begin
            check($sformatf("%s_a%0d", tag, n), a1, ea[x]);
            check($sformatf("%s_b%0d", tag, n), b1, eb[x]);
            check($sformatf("%s_s%0d", tag, n), sel1, es[x]);
          end
      if (vld1) v++;
      if (done1 && d1 < 0) d1 = n;
      if (done3 && d3 < 0) d3 = n;
      @(negedge clk);
      n++;
    end
    check({tag, "_vldcnt"}, v, 1600);
    check({tag, "_done1_t"}, d1, 1601);
    check({tag, "_done3_t"}, d3, 1603);
  endtask

  initial begin
    logic [31:0] rz, rr;
    rz = ref_sig(1'b1, 1'b0);
    rr = ref_sig(1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_pass", pass1, 0);
    check("rst_sig", sig1, SEED);
    check("rst_sig3", sig3, SEED);
    check("rst_cnt", cnt1, 0);
    check("rst_vld", vld1, 0);
    check("rst_a", a1, 0);
    rst = 1'b0;
    @(negedge clk);

    // run 1: real ALU function, both latencies
    golden = rr;
    do_start();
    check("r1_busy", busy1, 1);
    check("r1_vld", vld1, 1);
    wait_done("r1", 1'b1);
    check("r1_sig1", sig1, rr);
    check("r1_sig3", sig3, rr);
    check("r1_pass1", pass1, 1);
    check("r1_pass3", pass3, 1);
    check("r1_cnt", cnt1, 1600);
    check("r1_busy_end", busy1, 0);

    // run 2: all-zero ALU
    zero_mode = 1'b1;
    golden = rz;
    do_start();
    wait_done("r2", 1'b0);
    check("r2_pass", pass1, 1);
    check("r2_cnt", cnt1, 1600);
    check("r2_sig", sig1, rz);

    // run 3: wrong golden
    golden = rz ^ 32'h1;
    do_start();
    wait_done("r3", 1'b0);
    check("r3_pass", pass1, 0);
    check("r3_done", done1, 1);
    check("r3_sig", sig1, rz);

    // run 4: single corrupted flag on vector 777
    golden = rz;
    fault = 1'b1;
    do_start();
    wait_done("r4", 1'b0);
    fault = 1'b0;
    check("r4_sig", sig1, ref_sig(1'b1, 1'b1));
    check("r4_sig3", sig3, ref_sig(1'b1, 1'b1));
    check("r4_differs", sig1 != rz, 1);
    check("r4_pass", pass1, 0);

    // run 5: reset mid-run, then clean run
    do_start();
    repeat (500) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("r5_busy", busy1, 0);
    check("r5_done", done1, 0);
    check("r5_sig", sig1, SEED);
    check("r5_cnt", cnt1, 0);
    check("r5_vld", vld1, 0);
    check("r5_b", b1, 0);
    check("r5_sel", sel1, 0);
    rst = 1'b0;
    do_start();
    wait_done("r5b", 1'b0);
    check("r5b_sig", sig1, rz);
    check("r5b_pass", pass1, 1);

    // run 6: start while busy is ignored, start in DONE restarts
    do_start();
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("r6_a", a1, 0);
    check("r6_b", b1, 12000);
    check("r6_cnt", cnt1, 6);
    check("r6_busy", busy1, 1);
    begin
      int w = 0;
      while (!(done1 && done3) && w < 2100) begin
        @(negedge clk);
        w++;
      end
    end
    check("r6_done", done1, 1);
    do_start();
    check("r6_rs_sig", sig1, SEED);
    check("r6_rs_done", done1, 0);
    check("r6_rs_busy", busy1, 1);
    check("r6_rs_cnt", cnt1, 0);
    check("r6_rs_vld", vld1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
